// File: rtl/snd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snd_pkg
// Purpose  : Shared constants and helpers for the I2S sound mixer.
//            - silence_code : offset-binary silence value (1 << (SW-1))
//            - mix_width    : signed mix width S = SW + clog2(NCH/2)
//            - LEFT / RIGHT : word-select slot encoding on LRCK
// Revision : 1.0 - initial release
// ============================================================================
package snd_pkg;

  localparam int LEFT  = 0;
  localparam int RIGHT = 1;

  // Offset-binary mid-scale, used as the reset/idle value of every channel.
  function automatic int silence_code(input int sw);
    return 1 << (sw - 1);
  endfunction

  // Width that holds the sum of NCH/2 signed SW-bit samples without overflow.
  function automatic int mix_width(input int sw, input int nch);
    return sw + $clog2(nch / 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snd_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S transmitter. Divides clk down to BCLK, tracks the bit slot
//            bc, drives LRCK and shifts a parallel {L,R} word out MSB first
//            with the standard one-BCLK delay after the LRCK transition.
// Ports    : clk        in  system clock
//            reset_n    in  synchronous active-low reset
//            frame_word in  {L,R} word, captured at frame load
//            bclk       out bit clock
//            lrck       out word select (0 = left)
//            sdata      out serial data
//            load       out one-clk pulse when frame_word is captured
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx
  import snd_pkg::*;
#(
  parameter int OW       = 16,
  parameter int BCLK_DIV = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2*OW-1:0] frame_word,
  output logic            bclk,
  output logic            lrck,
  output logic            sdata,
  output logic            load
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * OW);

  logic [DW-1:0]   div;
  logic [BW-1:0]   bc;
  logic [BW-1:0]   bc_nxt;
  logic [2*OW-1:0] shreg;
  logic [2*OW-1:0] shreg_nxt;
  logic            div_tc;
  logic            fall;

  assign div_tc = (div == DW'(BCLK_DIV - 1));
  // BCLK is about to toggle from 1 to 0: every serial output moves here.
  assign fall   = div_tc & bclk;

  always_comb begin
    bc_nxt    = (bc == BW'(2 * OW - 1)) ? '0 : bc + BW'(1);
    // Frame load lands one slot after LRCK drops, giving the I2S one-bit delay.
    shreg_nxt = (bc_nxt == BW'(1)) ? frame_word : {shreg[2*OW-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div   <= '0;
      bclk  <= 1'b0;
      lrck  <= 1'b0;
      sdata <= 1'b0;
      load  <= 1'b0;
      bc    <= '0;
      shreg <= '0;
    end else begin
      load <= 1'b0;
      if (div_tc) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + DW'(1);
      end
      if (fall) begin
        bc    <= bc_nxt;
        lrck  <= (bc_nxt >= BW'(OW)) ? 1'(RIGHT) : 1'(LEFT);
        shreg <= shreg_nxt;
        sdata <= shreg_nxt[2*OW-1];
        load  <= (bc_nxt == BW'(1));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snd_i2s_mixer.sv
`default_nettype none
// ============================================================================
// Module   : snd_i2s_mixer
// Purpose  : NCH offset-binary sample channels written from the port decoder,
//            mixed to left (even channels) / right (odd channels) and sent to
//            the DAC as an I2S stream.
// Ports    : clk        in  system clock
//            reset_n    in  synchronous active-low reset
//            wr_stb     in  one-clk channel write strobe
//            wr_ch      in  channel index (out-of-range writes are ignored)
//            wr_data    in  sample value
//            mute       in  frames load as zero while high
//            i2s_bclk   out bit clock
//            i2s_lrck   out word select (0 = left)
//            i2s_sdata  out serial data, MSB first
//            frame_stb  out one-clk pulse at each frame load
// Revision : 1.0 - initial release
// ============================================================================
module snd_i2s_mixer
  import snd_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int SW       = 8,
  parameter int OW       = 16,
  parameter int BCLK_DIV = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  wr_stb,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [SW-1:0]                         wr_data,
  input  logic                                  mute,
  output logic                                  i2s_bclk,
  output logic                                  i2s_lrck,
  output logic                                  i2s_sdata,
  output logic                                  frame_stb
);

  localparam int             CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int             S       = mix_width(SW, NCH);
  localparam logic [SW-1:0]  SILENCE = SW'(silence_code(SW));

  logic [SW-1:0]         ch    [NCH];
  logic signed [S-1:0]   s_ext [NCH];
  logic signed [S-1:0]   l_sum;
  logic signed [S-1:0]   r_sum;
  logic [OW+S-1:0]       l_pad;
  logic [OW+S-1:0]       r_pad;
  logic [OW-1:0]         l_word;
  logic [OW-1:0]         r_word;
  logic [2*OW-1:0]       frame_word;

  // Channel registers. Index compare against each i means any wr_ch >= NCH
  // simply matches nothing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) ch[i] <= SILENCE;
    end else if (wr_stb) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ch == CW'(i)) ch[i] <= wr_data;
      end
    end
  end

  // Offset-binary to two's complement: flipping the MSB re-centres 0x80 to 0.
  for (genvar i = 0; i < NCH; i++) begin : g_ext
    logic signed [SW-1:0] s_raw;
    assign s_raw    = signed'(ch[i] ^ SILENCE);
    assign s_ext[i] = S'(s_raw);
  end

  always_comb begin
    l_sum = '0;
    r_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((i % 2) == LEFT) l_sum = l_sum + s_ext[i];
      else                 r_sum = r_sum + s_ext[i];
    end
  end

  // Left-justify each S-bit sum into an OW-bit slot; the top OW bits of
  // {sum, OW zeros} are {sum, (OW-S) zeros} without a zero-width replicate.
  assign l_pad  = {l_sum, OW'(0)};
  assign r_pad  = {r_sum, OW'(0)};
  assign l_word = l_pad[OW+S-1 -: OW];
  assign r_word = r_pad[OW+S-1 -: OW];

  // Only sampled by the transmitter at the load slot, so mute and channel
  // writes never disturb a frame already in the shift register.
  assign frame_word = mute ? '0 : {l_word, r_word};

  i2s_tx #(
    .OW       (OW),
    .BCLK_DIV (BCLK_DIV)
  ) u_tx (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_word (frame_word),
    .bclk       (i2s_bclk),
    .lrck       (i2s_lrck),
    .sdata      (i2s_sdata),
    .load       (frame_stb)
  );

endmodule
`default_nettype wire

// File: tb/tb_snd_i2s_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snd_i2s_mixer
// Purpose  : Self-checking bench for snd_i2s_mixer (NCH=4 main instance plus
//            an NCH=6 instance for the wider-mix and out-of-range cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snd_i2s_mixer;

  localparam int OW = 16;
  localparam int BD = 2;
  localparam int FR = 2 * OW;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_stb = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic       mute = 1'b0;
  logic       bclk, lrck, sdata, frame_stb;

  logic       wr_stb6 = 1'b0;
  logic [2:0] wr_ch6 = '0;
  logic [7:0] wr_data6 = '0;
  logic       mute6 = 1'b0;
  logic       bclk6, lrck6, sdata6, frame_stb6;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  snd_i2s_mixer #(.NCH(4), .SW(8), .OW(OW), .BCLK_DIV(BD)) u_dut (
    .clk(clk), .reset_n(reset_n), .wr_stb(wr_stb), .wr_ch(wr_ch),
    .wr_data(wr_data), .mute(mute), .i2s_bclk(bclk), .i2s_lrck(lrck),
    .i2s_sdata(sdata), .frame_stb(frame_stb));

  snd_i2s_mixer #(.NCH(6), .SW(8), .OW(OW), .BCLK_DIV(BD)) u_dut6 (
    .clk(clk), .reset_n(reset_n), .wr_stb(wr_stb6), .wr_ch(wr_ch6),
    .wr_data(wr_data6), .mute(mute6), .i2s_bclk(bclk6), .i2s_lrck(lrck6),
    .i2s_sdata(sdata6), .frame_stb(frame_stb6));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Everything is derived from n = clk edges since reset released: BCLK
  // toggles every BD edges, a slot lasts 2*BD edges, a frame FR slots.
  int          n = 0;
  bit          model_ok = 1'b0;
  int          model_ch [4];
  logic [31:0] exp_word = '0;

  function automatic logic [31:0] mix_model(input int c [4]);
    int l, r;
    l = (c[0] - 128) + (c[2] - 128);
    r = (c[1] - 128) + (c[3] - 128);
    l = l * 128;           // 9-bit sum left-justified into 16 bits
    r = r * 128;
    return {16'(l), 16'(r)};
  endfunction

  always @(posedge clk) begin
    model_ok = 1'b1;
    if (!reset_n) begin
      n = 0;
      for (int i = 0; i < 4; i++) model_ch[i] = 128;
      exp_word = '0;
    end else begin
      n = n + 1;
      if ((n % (2 * BD)) == 0 && ((n / (2 * BD)) % FR) == 1)
        exp_word = mute ? 32'h0 : mix_model(model_ch);
      if (wr_stb) model_ch[wr_ch] = int'(wr_data);
    end
  end

  // ---------------- per-cycle compare + frame receiver ----------------
  logic [31:0] rx = '0, rx6 = '0, rx_word = '0, rx6_word = '0;
  int          frames_done = 0;

  always @(negedge clk) begin
    if (model_ok) begin
      int fe, bc;
      logic e_sd;
      fe = n / (2 * BD);
      bc = fe % FR;
      if (fe == 0) e_sd = 1'b0;
      else         e_sd = exp_word[FR - 1 - ((bc + FR - 1) % FR)];
      check("bclk", bclk, 32'((n / BD) % 2));
      check("lrck", lrck, (bc >= OW) ? 32'd1 : 32'd0);
      check("frame_stb", frame_stb, (n > 0 && (n % (2 * BD)) == 0 && bc == 1) ? 32'd1 : 32'd0);
      check("sdata", sdata, 32'(e_sd));
      if (n > 0 && (n % (2 * BD)) == 0) begin
        rx  = {rx[30:0], sdata};
        rx6 = {rx6[30:0], sdata6};
        if (bc == 0 && fe >= FR) begin
          rx_word  = rx;
          rx6_word = rx6;
          frames_done++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input logic [7:0] d);
    wr_stb = 1'b1; wr_ch = 2'(c); wr_data = d;
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic wr6(input int c, input logic [7:0] d);
    wr_stb6 = 1'b1; wr_ch6 = 3'(c); wr_data6 = d;
    tick();
    wr_stb6 = 1'b0;
  endtask

  task automatic wait_bc(input int target);
    for (int k = 0; k < 300; k++) begin
      tick();
      if ((n % (2 * BD)) == 0 && ((n / (2 * BD)) % FR) == target) return;
    end
    check("wait_bc_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_frame();
    int start;
    start = frames_done;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (frames_done != start) return;
    end
    check("wait_frame_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_frames2();
    wait_frame();
    wait_frame();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    int k;
    // 1. reset and idle frames
    repeat (3) tick();
    check("reset_bclk", bclk, 0);
    check("reset_sdata", sdata, 0);
    reset_n = 1'b1;
    for (k = 0; k < 200 && !frame_stb; k++) tick();
    for (k = 1; k <= 200; k++) begin
      tick();
      if (frame_stb) break;
    end
    check("frame_period", k, 128);
    wait_frames2();
    check("idle_frame", rx_word, 32'h0000_0000);

    // 2. ch0 = 0xFF
    wr(0, 8'hFF);
    wait_frames2();
    check("ch0_ff_frame", rx_word, 32'h3F80_0000);
    wait_bc(3);
    check("ch0_ff_bit13_at_bc3", sdata, 1);
    check("lrck_left_at_bc3", lrck, 0);

    // 3. full-scale both ways
    wr(0, 8'h00); wr(2, 8'h00); wr(1, 8'hFF); wr(3, 8'hFF);
    wait_frames2();
    check("fullscale_frame", rx_word, 32'h8000_7F00);

    // 4. mid-frame write and write coincident with the load
    wr(0, 8'h80); wr(1, 8'h80); wr(2, 8'h80); wr(3, 8'h80);
    wait_frames2();
    check("silence_frame", rx_word, 32'h0000_0000);
    wait_bc(5);
    wr(1, 8'h90);
    wait_frame();
    check("midframe_write_current", rx_word, 32'h0000_0000);
    wait_frame();
    check("midframe_write_next", rx_word, 32'h0000_0800);
    wait_bc(0);
    repeat (2 * BD - 1) tick();
    wr_stb = 1'b1; wr_ch = 2'd1; wr_data = 8'hA0;
    tick();
    wr_stb = 1'b0;
    check("load_stb_with_write", frame_stb, 1);
    wait_frame();
    check("load_write_prevalue", rx_word, 32'h0000_0800);
    wait_frame();
    check("load_write_next", rx_word, 32'h0000_1000);

    // 5. mute
    mute = 1'b1;
    wr(0, 8'hFF);
    wait_frames2();
    check("muted_frame", rx_word, 32'h0000_0000);
    mute = 1'b0;
    wait_frames2();
    check("unmuted_frame", rx_word, 32'h3F80_1000);
    wait_bc(10);
    mute = 1'b1;
    wait_frame();
    check("mute_midframe_current", rx_word, 32'h3F80_1000);
    wait_frame();
    check("mute_midframe_next", rx_word, 32'h0000_0000);
    mute = 1'b0;

    // 5b. NCH=6: out-of-range channels ignored, S=10 justification
    wr6(6, 8'hFF); wr6(7, 8'hFF);
    wait_frames2();
    check("nch6_out_of_range", rx6_word, 32'h0000_0000);
    wr6(4, 8'hFF); wr6(5, 8'h00);
    wait_frames2();
    check("nch6_ch4_ch5", rx6_word, 32'h1FC0_E000);

    // 6. mid-frame reset
    wait_bc(20);
    check("lrck_right_at_bc20", lrck, 1);
    reset_n = 1'b0;
    tick();
    check("midreset_bclk", bclk, 0);
    check("midreset_lrck", lrck, 0);
    check("midreset_sdata", sdata, 0);
    check("midreset_stb", frame_stb, 0);
    reset_n = 1'b1;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (frame_stb) break;
    end
    check("first_load_after_reset", k, 4);
    wait_frame();
    check("post_reset_frame", rx_word, 32'h0000_0000);
    check("post_reset_frame6", rx6_word, 32'h0000_0000);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
